// File: rtl/calc_pkg.sv
// Shared encodings and glyph constants for the calculator display path.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package calc_pkg;

    localparam logic [1:0] ST_ERRO  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam int N_DIGITS = 8;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DASH  = 7'h3F;
    localparam seg7_t SEG_E     = 7'h06;
    localparam seg7_t SEG_R     = 7'h2F;
    localparam seg7_t SEG_O     = 7'h23;

    // "Erro" occupies digits 3..0; everything above is dark.
    function automatic seg7_t err_glyph(input logic [2:0] idx);
        case (idx)
            3'd3:       err_glyph = SEG_E;
            3'd2, 3'd1: err_glyph = SEG_R;
            3'd0:       err_glyph = SEG_O;
            default:    err_glyph = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes map to a dash.
module bcd_to_seg7
    import calc_pkg::*;
(
    input  bcd_t  bcd,
    output seg7_t seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Reassembles the core's serial BCD digit stream into a double-buffered frame and
// scans it onto an 8-digit common-anode 7-segment display with blanking and an error screen.
module calc_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  data,
    input  logic [3:0]  pos,
    input  logic [1:0]  status,
    output logic [7:0]  an,
    output seg7_t       seg,
    output logic        dp,
    output logic        err
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [2:0]                pos_q;
    logic                      wr_q;
    bcd_t [N_DIGITS-1:0]       frame_buf;
    bcd_t [N_DIGITS-1:0]       shadow;
    logic [DIV_W-1:0]          div;
    logic [2:0]                scan;
    logic [N_DIGITS-1:0]       upper_zero;
    seg7_t [N_DIGITS-1:0]      dec_seg;
    seg7_t                     glyph;
    logic                      commit;

    // data trails pos by a cycle, so the registered index lines up with it.
    assign commit = wr_q && (pos_q == 3'd7);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos_q     <= '0;
            wr_q      <= 1'b0;
            frame_buf <= '0;
            shadow    <= '0;
        end else begin
            pos_q <= pos[2:0];
            wr_q  <= ((status == ST_BUSY) || (status == ST_ERRO)) && !pos[3];
            if (wr_q)
                frame_buf[pos_q] <= data;
            if (commit) begin
                shadow    <= frame_buf;
                shadow[7] <= data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (status == ST_ERRO)
            err <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div  <= '0;
            scan <= '0;
        end else if (div == DIV_LAST) begin
            div  <= '0;
            scan <= scan + 3'd1;
        end else begin
            div  <= div + DIV_W'(1);
        end
    end

    // upper_zero[i]: every digit from i up to the top of the frame is zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[N_DIGITS-1] = (shadow[N_DIGITS-1] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--)
            upper_zero[i] = upper_zero[i+1] && (shadow[i] == 4'd0);
    end

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_dec
        bcd_to_seg7 u_dec (
            .bcd (shadow[i]),
            .seg (dec_seg[i])
        );
    end

    always_comb begin
        glyph = dec_seg[scan];
        if (err)
            glyph = err_glyph(scan);
        else if (shadow[scan] > 4'd9)
            glyph = SEG_DASH;
        else if (BLANK_ZEROS && (scan != 3'd0) && upper_zero[scan])
            glyph = SEG_BLANK;
    end

    // an and seg share one register stage so they always name the same digit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(8'b1 << scan);
            seg <= glyph;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: one instance with leading-zero blanking, one without.
module tb_calc_display;
    import calc_pkg::*;

    logic        clock;
    logic        reset;
    logic [3:0]  data;
    logic [3:0]  pos;
    logic [1:0]  status;
    logic [7:0]  an1, an0;
    seg7_t       seg1, seg0;
    logic        dp1, dp0, err1, err0;

    int tests = 0;
    int fails = 0;

    calc_display #(.REFRESH_DIV(4), .BLANK_ZEROS(1'b1)) dut (
        .clock(clock), .reset(reset), .data(data), .pos(pos), .status(status),
        .an(an1), .seg(seg1), .dp(dp1), .err(err1)
    );

    calc_display #(.REFRESH_DIV(4), .BLANK_ZEROS(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .data(data), .pos(pos), .status(status),
        .an(an0), .seg(seg0), .dp(dp0), .err(err0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // frame[i] is slot i; data follows pos by one cycle.
    task automatic drive_frame(input logic [7:0][3:0] frame, input logic [1:0] st7);
        for (int k = 0; k <= 8; k++) begin
            pos    = (k < 8) ? 4'(k) : 4'hF;
            status = (k < 7) ? ST_BUSY : ((k == 7) ? st7 : ST_READY);
            data   = (k > 0) ? frame[k-1] : 4'd0;
            tick();
        end
        pos = 4'hF; status = ST_READY; data = 4'd0;
    endtask

    task automatic capture(output logic [7:0][6:0] s1, output logic [7:0][6:0] s0,
                           output logic [7:0] seen1, output logic [7:0] seen0);
        s1 = '1; s0 = '1; seen1 = '0; seen0 = '0;
        repeat (2) @(posedge clock);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            for (int i = 0; i < 8; i++) begin
                if (an1 == ~(8'b1 << i)) begin s1[i] = seg1; seen1[i] = 1'b1; end
                if (an0 == ~(8'b1 << i)) begin s0[i] = seg0; seen0[i] = 1'b1; end
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0][6:0] s1, s0, e1, e0;
        logic [7:0] n1, n0;
        reset = 1'b0;
        repeat (3) tick();
        tests++; if (an1 !== 8'hFF) begin fails++; $display("FAIL reset_an: got %h want ff", an1); end
        tests++; if (seg1 !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h want 7f", seg1); end
        tests++; if (err1 !== 1'b0 || err0 !== 1'b0) begin fails++; $display("FAIL reset_err: got %b/%b want 0/0", err1, err0); end
        tests++; if (dp1 !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", dp1); end
        reset = 1'b1;
        repeat (4) tick();
        tests++; if (an1 !== 8'hFE) begin fails++; $display("FAIL idle_an: got %h want fe", an1); end
        tests++; if (seg1 !== 7'h40) begin fails++; $display("FAIL idle_seg: got %h want 40", seg1); end
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        e0 = {8{7'h40}};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF || n0 !== 8'hFF) begin fails++; $display("FAIL idle_scan: seen %h/%h want ff/ff", n1, n0); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL idle_d%0d: got %h want %h", i, s1[i], e1[i]); end
            tests++; if (s0[i] !== e0[i]) begin fails++; $display("FAIL idle_nb_d%0d: got %h want %h", i, s0[i], e0[i]); end
        end
    endtask

    task automatic test_frame();
        logic [7:0][6:0] s1, s0, e1, e0;
        logic [7:0] n1, n0;
        drive_frame(32'h0000_1234, ST_BUSY);
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
        e0 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF || n0 !== 8'hFF) begin fails++; $display("FAIL frame_scan: seen %h/%h want ff/ff", n1, n0); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL frame_d%0d: got %h want %h", i, s1[i], e1[i]); end
            tests++; if (s0[i] !== e0[i]) begin fails++; $display("FAIL frame_nb_d%0d: got %h want %h", i, s0[i], e0[i]); end
        end
    endtask

    task automatic test_blank_modes();
        logic [7:0][6:0] s1, s0, e1, e0;
        logic [7:0] n1, n0;
        drive_frame(32'h0000_1207, ST_BUSY);
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40, 7'h78};
        e0 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40, 7'h78};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF || n0 !== 8'hFF) begin fails++; $display("FAIL blank_scan: seen %h/%h want ff/ff", n1, n0); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL blank_d%0d: got %h want %h", i, s1[i], e1[i]); end
            tests++; if (s0[i] !== e0[i]) begin fails++; $display("FAIL blank_nb_d%0d: got %h want %h", i, s0[i], e0[i]); end
        end
    endtask

    task automatic test_no_tearing();
        logic [7:0][6:0] s1, s0, e1;
        logic [7:0] n1, n0;
        for (int k = 0; k <= 6; k++) begin
            pos    = (k < 6) ? 4'(k) : 4'hF;
            status = (k < 6) ? ST_BUSY : ST_READY;
            data   = (k > 0) ? 4'd9 : 4'd0;
            tick();
        end
        pos = 4'hF; status = ST_READY; data = 4'd0;
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40, 7'h78};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF) begin fails++; $display("FAIL tear_scan: seen %h want ff", n1); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL tear_d%0d: got %h want %h", i, s1[i], e1[i]); end
        end
    endtask

    task automatic test_invalid();
        logic [7:0][6:0] s1, s0, e1, e0;
        logic [7:0] n1, n0;
        drive_frame(32'h0000_0C05, ST_BUSY);
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h12};
        e0 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h40, 7'h12};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF || n0 !== 8'hFF) begin fails++; $display("FAIL inval_scan: seen %h/%h want ff/ff", n1, n0); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL inval_d%0d: got %h want %h", i, s1[i], e1[i]); end
            tests++; if (s0[i] !== e0[i]) begin fails++; $display("FAIL inval_nb_d%0d: got %h want %h", i, s0[i], e0[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0][6:0] s1, s0, e1, e0;
        logic [7:0] n1, n0;
        drive_frame(32'h1111_1111, ST_BUSY);
        drive_frame(32'h0000_0098, ST_BUSY);
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h00};
        e0 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10, 7'h00};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF || n0 !== 8'hFF) begin fails++; $display("FAIL b2b_scan: seen %h/%h want ff/ff", n1, n0); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL b2b_d%0d: got %h want %h", i, s1[i], e1[i]); end
            tests++; if (s0[i] !== e0[i]) begin fails++; $display("FAIL b2b_nb_d%0d: got %h want %h", i, s0[i], e0[i]); end
        end
    endtask

    task automatic test_error();
        logic [7:0][6:0] s1, s0, e1;
        logic [7:0] n1, n0;
        tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL err_pre: got %b want 0", err1); end
        status = ST_ERRO; pos = 4'hF;
        tick();
        status = ST_READY;
        tests++; if (err1 !== 1'b1 || err0 !== 1'b1) begin fails++; $display("FAIL err_set: got %b/%b want 1/1", err1, err0); end
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h23};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF || n0 !== 8'hFF) begin fails++; $display("FAIL err_scan: seen %h/%h want ff/ff", n1, n0); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL err_d%0d: got %h want %h", i, s1[i], e1[i]); end
            tests++; if (s0[i] !== e1[i]) begin fails++; $display("FAIL err_nb_d%0d: got %h want %h", i, s0[i], e1[i]); end
        end
        tests++; if (err1 !== 1'b1) begin fails++; $display("FAIL err_hold: got %b want 1", err1); end
        #2 reset = 1'b0;
        #1;
        tests++; if (an1 !== 8'hFF || an0 !== 8'hFF) begin fails++; $display("FAIL err_rst_an: got %h/%h want ff/ff", an1, an0); end
        tests++; if (err1 !== 1'b0 || err0 !== 1'b0) begin fails++; $display("FAIL err_rst_err: got %b/%b want 0/0", err1, err0); end
        tests++; if (seg1 !== 7'h7F) begin fails++; $display("FAIL err_rst_seg: got %h want 7f", seg1); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_err_commit();
        logic [7:0][6:0] s1, s0, e1;
        logic [7:0] n1, n0;
        drive_frame(32'h0000_0042, ST_ERRO);
        tests++; if (err1 !== 1'b1) begin fails++; $display("FAIL errc_set: got %b want 1", err1); end
        e1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h23};
        capture(s1, s0, n1, n0);
        tests++; if (n1 !== 8'hFF) begin fails++; $display("FAIL errc_scan: seen %h want ff", n1); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (s1[i] !== e1[i]) begin fails++; $display("FAIL errc_d%0d: got %h want %h", i, s1[i], e1[i]); end
        end
    endtask

    initial begin
        reset = 1'b0; data = 4'd0; pos = 4'hF; status = ST_READY;
        test_reset();
        test_frame();
        test_blank_modes();
        test_no_tearing();
        test_invalid();
        test_back_to_back();
        test_error();
        test_err_commit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Downstream consumer of the calculator core's serial digit stream (`data`, `pos`, `status`).
- Reassembles the 8 BCD digits into a double-buffered frame.
- Drives a time-multiplexed 8-digit, common-anode 7-segment display.
- Adds leading-zero blanking, an invalid-digit glyph and a latched "Erro" screen.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit before the scan advances (>=2).
- BLANK_ZEROS, 1, 1 = blank leading zeros (digit 0 never blanked); 0 = show all digits.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- data  in  4  BCD digit from the core; refers to the `pos` value presented one cycle earlier
- pos  in  4  digit index 0..7 from the core; values >7 are ignored
- status  in  2  core status: 00 error, 01 busy, 10 ready, 11 reserved (treated as ready)
- an  out  8  anode enables, active-low, an[i] = digit i (0 = least significant)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low, constant 1 (off)
- err  out  1  error latched

Behaviour:
- Reset (reset=0, async):
  - buf[0..7]=0, shadow[0..7]=0.
  - pos_q=0, wr_q=0, err=0.
  - div=0, scan=0.
  - an=8'hFF, seg=7'h7F, dp=1.
- Capture stage, one register stage:
  - Every cycle: pos_q<=pos; wr_q<=(status==01 || status==00) && pos<=7.
  - When wr_q=1: buf[pos_q]<=data.
  - data is sampled in the same cycle as the write, i.e. one cycle after pos.
- Frame commit:
  - On a write with pos_q==7, the next-cycle shadow<=buf, with slot 7 taking the data being written that cycle.
  - shadow changes only at a commit; partial frames are never displayed.
  - Writes to slots 0..6 without a following slot-7 write never reach shadow.
- Error latch:
  - status==00 sampled on any cycle sets err<=1 on the next edge.
  - Only reset clears err.
  - While err=1, capture and commit continue internally but display content is overridden (see below).
- Scan timer:
  - div counts 0..REFRESH_DIV-1 and wraps to 0.
  - When div==REFRESH_DIV-1: scan<=scan+1, wrapping 7->0.
- Output stage, registered, one cycle after scan/shadow change:
  - an<=~(8'b1<<scan).
  - seg<=glyph(scan), where glyph selection is:
    - err=1: digits 3,2,1,0 show E(0x06), r(0x2F), r(0x2F), o(0x23); digits 7..4 blank(0x7F).
    - shadow[scan]>9: '-' (0x3F).
    - BLANK_ZEROS=1 and scan!=0 and shadow[j]==0 for all j>=scan: blank (0x7F).
    - Otherwise decimal: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
- Simultaneous events:
  - Commit and scan advance in the same cycle: both take effect; the next output register load uses the new shadow and new scan.
  - status==00 together with a slot-7 write: commit happens and err sets; the display shows Erro.
- Reset mid-frame: all buffers are cleared immediately; a partial frame is discarded.
- No ghosting requirement: an and seg are updated in the same register stage, so they never refer to different digits.

Decomposition:
- Package calc_pkg holds:
  - status encodings ST_ERRO=2'b00, ST_BUSY=2'b01, ST_READY=2'b10;
  - N_DIGITS=8;
  - a seg7_t typedef (logic [6:0]);
  - glyph constants SEG_BLANK, SEG_DASH, SEG_E, SEG_R, SEG_O.
- One sub-module, bcd_to_seg7: combinational 4-bit to seg7_t, with '-' for >9.
- Capture, commit, error latch and scan logic stay in calc_display.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles -> an=FF, seg=7F, err=0. Release and wait REFRESH_DIV=4 cycles -> an=FE, seg=0x40 (digit 0 shows "0"); digits 1..7 blank.
- Frame 00001234:
  - Stimulus: status=01, pos=0..7 on consecutive cycles with data one cycle late = 4,3,2,1,0,0,0,0.
  - Required: shadow updates one cycle after the slot-7 write.
  - Scan shows 0x19, 0x30, 0x24, 0x79 on an=FE, FD, FB, F7; digits 4..7 show 7F.
- No tearing: stream slots 0..5 only, then status=10 -> displayed digits remain the previous frame's values.
- BLANK_ZEROS=0 with value 1207 -> digits 7..4 show 0x40; the embedded 0 on digit 1 always shows 0x40 in both modes.
- Invalid digit: data=4'hC into slot 2, then commit -> digit 2 seg=0x3F.
- Error: status=00 for one cycle, then status=10 -> err=1 from the next edge. Digits 3..0 show 06, 2F, 2F, 23 and digits 7..4 show 7F until reset; reset then clears err and an=FF asynchronously.
